// File: rtl/inst_fetch.sv
// Instruction fetch/issue unit: owns the PC, fetches words over a req/ack
// handshake and presents a stable Inst/Inst_Valid pair to the control unit.
module inst_fetch #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [1:0]        PC_SEL,
    input  logic [25:0]       Br_Offset,
    input  logic [ADDR_W-1:0] Br_Target,
    input  logic              Adv,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       Inst,
    output logic              Inst_Valid,
    output logic [ADDR_W-1:0] PC,
    output logic [CNT_W-1:0]  Inst_Count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [31:0]        inst_q, inst_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               fetch_done;
    logic               adv_take;
    logic [ADDR_W-1:0]  pc_next;
    logic [ADDR_W-1:0]  pc_off;
    logic [27:0]        off_bytes;
    logic               unused_tgt_bits;

    // Word offset scaled to bytes, then fitted to the PC width (sign-extended or truncated).
    assign off_bytes = {Br_Offset, 2'b00};

    generate
        if (ADDR_W < 28) begin : g_off_trunc
            logic unused_off_bits;
            assign pc_off          = off_bytes[ADDR_W-1:0];
            assign unused_off_bits = ^off_bytes[27:ADDR_W];
        end else if (ADDR_W == 28) begin : g_off_exact
            assign pc_off = off_bytes;
        end else begin : g_off_sext
            assign pc_off = {{(ADDR_W-28){Br_Offset[25]}}, off_bytes};
        end
    endgenerate

    assign unused_tgt_bits = ^Br_Target[1:0];

    // mem_ack only counts while a fetch is outstanding; Adv only while a word is held.
    assign fetch_done = (state_q == S_FETCH) && mem_ack;
    assign adv_take   = (state_q == S_HOLD) && valid_q && Adv && (PC_SEL != 2'b00);

    always_comb begin
        pc_next = pc_q;
        case (PC_SEL)
            2'b01:   pc_next = pc_q + ADDR_W'(4);
            2'b10:   pc_next = pc_q + pc_off;
            2'b11:   pc_next = {Br_Target[ADDR_W-1:2], 2'b00};
            default: pc_next = pc_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (mem_ack)  state_d = S_HOLD;
            S_HOLD:  if (adv_take) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req = (state_q == S_FETCH);
    end

    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (fetch_done) begin
            inst_d  = mem_rdata;
            valid_d = 1'b1;
        end
        if (adv_take) begin
            pc_d    = pc_next;
            valid_d = 1'b0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_addr   = pc_q;
    assign PC         = pc_q;
    assign Inst       = inst_q;
    assign Inst_Valid = valid_q;
    assign Inst_Count = cnt_q;

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch/issue unit. It is the producer side of the 32-bit `Inst` word that the control unit decodes.
- Holds the PC and fetches instruction words from instruction memory over a req/ack handshake.
- Presents a stable `Inst` with a valid flag, then advances the PC on the control unit's `PC_SEL` command: hold, increment, relative branch, absolute branch.
- Sits between instruction memory and the control unit in the LEGv8 datapath.

Parameters:
- ADDR_W, 16, PC and memory address width in bits.
- RESET_PC, 0, PC value loaded on reset; must be a multiple of 4.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- PC_SEL  input  2  next-PC command: 00 hold/repeat, 01 PC+4, 10 PC-relative branch, 11 absolute target.
- Br_Offset  input  26  signed word offset for PC_SEL=10.
- Br_Target  input  ADDR_W  byte address for PC_SEL=11.
- Adv  input  1  control unit finished with the current `Inst`; apply `PC_SEL`.
- mem_req  output  1  instruction memory read request.
- mem_addr  output  ADDR_W  read address; equals PC.
- mem_ack  input  1  single-cycle read-complete pulse; `mem_rdata` is valid in the same cycle.
- mem_rdata  input  32  instruction word from memory.
- Inst  output  32  instruction presented to the control unit.
- Inst_Valid  output  1  `Inst` holds a fetched, unconsumed word.
- PC  output  ADDR_W  address of `Inst`, or of the fetch in progress.
- Inst_Count  output  CNT_W  retired-instruction count, saturating.

Behaviour:
- **Reset (synchronous):**
  - State goes to S_IDLE; PC = RESET_PC; Inst = 0; Inst_Valid = 0; mem_req = 0; Inst_Count = 0.
  - Reset overrides every other input in the same cycle.
  - A fetch in flight is abandoned and `mem_req` drops on the reset edge.
- **S_IDLE:**
  - One cycle, mem_req = 0. Any `mem_ack` is discarded, which flushes stale acks after a mid-operation reset.
  - Goes to S_FETCH the next cycle.
- **S_FETCH:**
  - mem_req = 1; mem_addr = PC, held stable until ack.
  - On `mem_ack`: Inst <= mem_rdata, Inst_Valid <= 1, mem_req <= 0, go to S_HOLD.
  - With no ack, stays in S_FETCH indefinitely; there is no timeout.
- **S_HOLD:**
  - Inst and Inst_Valid are held; mem_req = 0.
  - `Adv` with PC_SEL = 00: no PC change, Inst_Valid stays 1, no refetch. This serves multicycle instructions such as LDUR. Inst_Count is unchanged.
  - `Adv` with PC_SEL ≠ 00:
    - PC <= next PC.
    - Inst_Valid <= 0; Inst is held at its old value.
    - Inst_Count <= Inst_Count + 1, saturating at all-ones.
    - Go to S_FETCH.
- **Adv gating:** `Adv` is ignored whenever Inst_Valid = 0. `mem_ack` is ignored outside S_FETCH.
- **Next-PC arithmetic** (all results modulo 2^ADDR_W, wrap silently):
  - 01: PC + 4.
  - 10: PC + (sign-extended Br_Offset << 2), truncated to ADDR_W.
  - 11: Br_Target with bits [1:0] forced to 0.
- **Latency:**
  - `mem_ack` to Inst_Valid high: 1 cycle.
  - `Adv` to mem_req high: 1 cycle.
  - With zero-wait memory (ack in the first req cycle), steady-state throughput is one instruction per 2 cycles.
- **Timing to the control unit:** the control unit samples on the falling edge. `Inst` changes only on rising edges, so it is stable across the entire high and low phase it is sampled in.
- **Memory contract:** `mem_ack` is a 1-cycle pulse asserted only while mem_req = 1. Back-to-back acks are not required.

Test Plan:
- Reset, then zero-wait memory returning 0x8B020020 @0x0000 → mem_req high with addr 0x0000 in the 2nd cycle after reset; Inst = 0x8B020020 and Inst_Valid = 1 one cycle after ack.
- Adv with PC_SEL = 01 from PC 0x0004 → Inst_Valid drops, PC = 0x0008, mem_addr = 0x0008 next cycle, Inst_Count 0→1.
- Adv with PC_SEL = 00 held for 3 cycles → PC, Inst and Inst_Valid unchanged; no mem_req; Inst_Count unchanged.
- Branches:
  - PC = 0x0010, PC_SEL = 10, Br_Offset = −2 → PC = 0x0008.
  - PC = 0xFFFC, PC_SEL = 01 → PC = 0x0000 (wrap).
  - PC_SEL = 11, Br_Target = 0x1237 → PC = 0x1234.
- Memory with 5-cycle ack latency and Reset asserted in wait cycle 3, late ack arriving during S_IDLE → ack ignored; Inst = 0, Inst_Valid = 0; refetch from RESET_PC.
- CNT_W = 4 parameter override, 20 PC_SEL = 01 advances → Inst_Count saturates at 15.
